// File: rtl/trigger_window_framer.sv
// Trigger window framer: on a trigger, frames a window of incoming samples as
// header (timestamp) + data words + footer (drop flag and word count), and
// buffers the frame words in a first-word-fall-through output FIFO.
//
// Output handshake: a word transfers on every rising CLK edge where
// DOUT_VALID and DOUT_READY are both high. DOUT_VALID never depends on
// DOUT_READY, and DOUT is held stable while DOUT_VALID is high and no transfer
// has occurred. The input side has no backpressure. Samples that arrive while
// the FIFO is full are dropped and reported in the footer and in OVERFLOW.
module trigger_window_framer #(
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_WINDOW_CLK = 100,
    parameter int FIFO_DEPTH     = 16,
    localparam int CNT_WIDTH     = $clog2(MAX_WINDOW_CLK + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [CNT_WIDTH-1:0]  WINDOW_CLK,
    input  logic                  TRIG,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DIN_VALID,
    output logic [DATA_WIDTH+1:0] DOUT,
    output logic                  DOUT_VALID,
    input  logic                  DOUT_READY,
    output logic                  DOUT_LAST,
    output logic                  BUSY,
    output logic                  OVERFLOW,
    output logic [1:0]            DBG_STATE
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FOOTER  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] timestamp;
    logic [CNT_WIDTH-1:0]  window_q;
    logic [CNT_WIDTH-1:0]  sample_cnt;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic                  drop_q;
    logic                  overflow_q;
    logic                  last_sample;
    logic [DATA_WIDTH-1:0] footer_payload;

    logic [OW-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           fifo_cnt;
    logic                  fifo_full, fifo_empty;
    logic                  fifo_wr_req, fifo_wr, fifo_rd;
    logic [OW-1:0]         fifo_wdata;

    // Full is taken from the registered occupancy, so a read in the same
    // cycle never makes room for a write that arrives while full.
    assign fifo_full   = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_wr     = fifo_wr_req && !fifo_full;
    assign fifo_rd     = !fifo_empty && DOUT_READY;
    assign last_sample = ((sample_cnt + CNT_WIDTH'(1)) == window_q);

    // Footer payload: drop flag just above the word count, all else zero.
    always_comb begin
        footer_payload                = '0;
        footer_payload[CNT_WIDTH-1:0] = word_cnt;
        footer_payload[CNT_WIDTH]     = drop_q;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and the FIFO write request for the current state.
    always_comb begin
        state_nxt   = state;
        fifo_wr_req = 1'b0;
        fifo_wdata  = '0;
        case (state)
            S_IDLE: begin
                if (TRIG && !fifo_full) begin
                    fifo_wr_req = 1'b1;
                    fifo_wdata  = {2'b01, timestamp};
                    state_nxt   = (WINDOW_CLK == '0) ? S_FOOTER : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (DIN_VALID) begin
                    fifo_wr_req = 1'b1;
                    fifo_wdata  = {2'b00, DIN};
                    if (last_sample) state_nxt = S_FOOTER;
                end
            end
            S_FOOTER: begin
                // The footer waits for space rather than being dropped.
                fifo_wr_req = 1'b1;
                fifo_wdata  = {2'b11, footer_payload};
                if (!fifo_full) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timestamp, window latch, sample/word counters and loss flags.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            timestamp  <= '0;
            window_q   <= '0;
            sample_cnt <= '0;
            word_cnt   <= '0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            timestamp <= timestamp + DATA_WIDTH'(1);
            case (state)
                S_IDLE: begin
                    if (TRIG) begin
                        if (fifo_full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            window_q   <= WINDOW_CLK;
                            sample_cnt <= '0;
                            word_cnt   <= '0;
                            drop_q     <= 1'b0;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (DIN_VALID) begin
                        sample_cnt <= sample_cnt + CNT_WIDTH'(1);
                        if (fifo_full) begin
                            drop_q     <= 1'b1;
                            overflow_q <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy qualifies them.
    always_ff @(posedge CLK) begin
        if (fifo_wr) mem[wr_ptr] <= fifo_wdata;
    end

    assign DOUT       = mem[rd_ptr];
    assign DOUT_VALID = !fifo_empty;
    assign DOUT_LAST  = DOUT_VALID && (DOUT[OW-1:OW-2] == 2'b11);
    assign BUSY       = (state != S_IDLE);
    assign OVERFLOW   = overflow_q;
    assign DBG_STATE  = state;

endmodule
